load_store_unit: RTL and testbench

Sits between the execute stage and the 64-word data memory and turns MIPS byte-addressed loads and stores into whole-word memory accesses. It handles:
- word, halfword and byte sizes;
- sign or zero extension on loads;
- read-modify-write for sub-word stores.

It drives the memory's read enable, write enable, word address and write data. It relies on the memory capturing read data at posedge and writing at negedge.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 140 ++++++++++++++
 tb/tb_load_store_unit.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals between the execute stage, the load/store unit and the 64-word memory.
// master = requester side (also supplies MemReadData); slave = the load/store unit.
interface load_store_unit_if #(
  parameter int WORD_ADDR_W = 6
);
  logic                   ReqValid;
  logic                   ReqReady;
  logic                   ReqStore;
  logic [1:0]             ReqSize;
  logic                   ReqUnsigned;
  logic [WORD_ADDR_W+1:0] ReqAddr;
  logic [31:0]            ReqWData;
  logic [31:0]            LoadData;
  logic                   LoadValid;
  logic                   StoreDone;
  logic                   AddrError;
  logic [WORD_ADDR_W-1:0] MemAddress;
  logic [31:0]            MemWriteData;
  logic                   MemoryRead;
  logic                   MemoryWrite;
  logic [31:0]            MemReadData;

  modport master (
    output ReqValid, ReqStore, ReqSize, ReqUnsigned, ReqAddr, ReqWData, MemReadData,
    input  ReqReady, LoadData, LoadValid, StoreDone, AddrError,
           MemAddress, MemWriteData, MemoryRead, MemoryWrite
  );

  modport slave (
    input  ReqValid, ReqStore, ReqSize, ReqUnsigned, ReqAddr, ReqWData, MemReadData,
    output ReqReady, LoadData, LoadValid, StoreDone, AddrError,
           MemAddress, MemWriteData, MemoryRead, MemoryWrite
  );
endinterface

// File: rtl/load_store_unit.sv
// MIPS byte/half/word loads and stores onto a word memory; load result 3 cycles after accept, store done 2 (word) or 4 (sub-word).
// One request in flight: ReqReady only in IDLE; misaligned/illegal requests are accepted, dropped and flagged with AddrError.
module load_store_unit #(
  parameter int WORD_ADDR_W = 6
) (
  input  logic             Clock,
  input  logic             Reset_n,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] MERGE = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]             state;
  logic [WORD_ADDR_W+1:0] addr_q;
  logic [1:0]             size_q;
  logic                   store_q;
  logic                   uns_q;
  logic [31:0]            wbuf_q;
  logic [31:0]            load_data_q;
  logic                   load_valid_q;
  logic                   store_done_q;
  logic                   addr_err_q;

  logic                   req_err;
  logic [7:0]             rd_byte;
  logic [15:0]            rd_half;
  logic [31:0]            load_ext;
  logic [31:0]            merged;

  always_comb begin
    req_err = (bus.ReqSize == 2'b11)
           || (bus.ReqSize == SZ_HALF && bus.ReqAddr[0])
           || (bus.ReqSize == SZ_WORD && bus.ReqAddr[1:0] != 2'b00);
  end

  // Lane extraction and sign/zero extension for the MERGE cycle of a load.
  always_comb begin
    rd_byte = 8'h00;
    case (addr_q[1:0])
      2'd0:    rd_byte = bus.MemReadData[7:0];
      2'd1:    rd_byte = bus.MemReadData[15:8];
      2'd2:    rd_byte = bus.MemReadData[23:16];
      default: rd_byte = bus.MemReadData[31:24];
    endcase
    rd_half = addr_q[1] ? bus.MemReadData[31:16] : bus.MemReadData[15:0];
    case (size_q)
      SZ_BYTE: load_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: load_ext = bus.MemReadData;
    endcase
  end

  // Sub-word store: replace only the addressed lane of the word just read.
  always_comb begin
    merged = bus.MemReadData;
    if (size_q == SZ_BYTE) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wbuf_q[7:0];
        2'd1:    merged[15:8]  = wbuf_q[7:0];
        2'd2:    merged[23:16] = wbuf_q[7:0];
        default: merged[31:24] = wbuf_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wbuf_q[15:0];
    end else begin
      merged[15:0] = wbuf_q[15:0];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      size_q       <= 2'b00;
      store_q      <= 1'b0;
      uns_q        <= 1'b0;
      wbuf_q       <= 32'h0;
      load_data_q  <= 32'h0;
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      store_done_q <= 1'b0;
      addr_err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ReqValid) begin
            addr_q  <= bus.ReqAddr;
            size_q  <= bus.ReqSize;
            store_q <= bus.ReqStore;
            uns_q   <= bus.ReqUnsigned;
            wbuf_q  <= bus.ReqWData;
            if (req_err) begin
              addr_err_q <= 1'b1;
            end else if (bus.ReqStore && bus.ReqSize == SZ_WORD) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: state <= MERGE;
        MERGE: begin
          if (store_q) begin
            wbuf_q <= merged;
            state  <= WRITE;
          end else begin
            load_data_q  <= load_ext;
            load_valid_q <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          store_done_q <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Memory controls depend only on state and latched registers, so they hold steady across the negedge write.
  assign bus.ReqReady     = (state == IDLE);
  assign bus.MemoryRead   = (state == READ);
  assign bus.MemoryWrite  = (state == WRITE);
  assign bus.MemAddress   = addr_q[WORD_ADDR_W+1:2];
  assign bus.MemWriteData = wbuf_q;
  assign bus.LoadData     = load_data_q;
  assign bus.LoadValid    = load_valid_q;
  assign bus.StoreDone    = store_done_q;
  assign bus.AddrError    = addr_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random requests against a word-array reference model; the memory model captures reads at posedge and writes at negedge.
module tb_load_store_unit;

  logic Clock = 1'b0;
  logic Reset_n;
  always #5 Clock = ~Clock;

  load_store_unit_if #(.WORD_ADDR_W(6)) bus();
  load_store_unit #(.WORD_ADDR_W(6)) dut (.Clock(Clock), .Reset_n(Reset_n), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int sd_cnt = 0;
  int last_pulse = 0;
  logic [5:0]  last_wr_addr = 6'd0;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  always @(posedge Clock) begin
    cyc++;
    if (bus.MemoryRead) bus.MemReadData <= mem[bus.MemAddress];
  end

  always @(negedge Clock) begin
    if (bus.MemoryRead) rd_cnt++;
    if (bus.MemoryWrite) begin
      wr_cnt++;
      last_wr_addr = bus.MemAddress;
      mem[bus.MemAddress] = bus.MemWriteData;
    end
    if (bus.StoreDone) sd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [7:0] a);
    int nb;
    if (sz == 2'b11) return 1'b1;
    nb = 1 << sz;
    return (a % nb) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic un, input logic [1:0] off);
    int nb;
    logic [31:0] v, m;
    nb = 1 << sz;
    v = w >> (8 * off);
    if (nb == 4) return v;
    m = (32'h1 << (8 * nb)) - 1;
    v = v & m;
    if (!un && v[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [31:0] wd);
    int nb;
    logic [31:0] m;
    nb = 1 << sz;
    if (nb == 4) return wd;
    m = ((32'h1 << (8 * nb)) - 1) << (8 * off);
    return (old & ~m) | ((wd << (8 * off)) & m);
  endfunction

  task automatic do_req(input logic st, input logic [1:0] sz, input logic un, input logic [7:0] a,
                        input logic [31:0] wd, input logic hold, input string tag);
    int n, lat, exp_lat, rd0, wr0;
    logic err;
    logic [5:0] w;
    err = model_err(sz, a);
    w = a[7:2];
    n = 0;
    while (bus.ReqReady !== 1'b1 && n < 20) begin step(); n++; end
    check({tag, ".ready"}, 32'(bus.ReqReady), 32'd1);
    bus.ReqValid = 1'b1;
    bus.ReqStore = st;
    bus.ReqSize = sz;
    bus.ReqUnsigned = un;
    bus.ReqAddr = a;
    bus.ReqWData = wd;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    step();
    if (!hold) bus.ReqValid = 1'b0;
    lat = 1;
    while (!(bus.LoadValid || bus.StoreDone || bus.AddrError) && lat < 12) begin step(); lat++; end
    last_pulse = cyc;
    exp_lat = err ? 1 : (st ? ((sz == 2'b10) ? 2 : 4) : 3);
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".kind"}, {29'd0, bus.LoadValid, bus.StoreDone, bus.AddrError},
          err ? 32'd1 : (st ? 32'd2 : 32'd4));
    check({tag, ".ready_at_pulse"}, 32'(bus.ReqReady), 32'd1);
    check({tag, ".reads"}, 32'(rd_cnt - rd0), (err || (st && sz == 2'b10)) ? 32'd0 : 32'd1);
    check({tag, ".writes"}, 32'(wr_cnt - wr0), (!err && st) ? 32'd1 : 32'd0);
    if (!err && !st) check({tag, ".data"}, bus.LoadData, model_load(ref_mem[w], sz, un, a[1:0]));
    if (!err && st) begin
      ref_mem[w] = model_store(ref_mem[w], sz, a[1:0], wd);
      check({tag, ".waddr"}, 32'(last_wr_addr), 32'(w));
    end
  endtask

  initial begin
    int p0, p1, sd0, wr0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    Reset_n = 1'b0;
    bus.ReqValid = 1'b0;
    bus.ReqStore = 1'b0;
    bus.ReqSize = 2'b00;
    bus.ReqUnsigned = 1'b0;
    bus.ReqAddr = 8'h00;
    bus.ReqWData = 32'h0;
    bus.MemReadData = 32'h0;
    #2;
    check("rst.ReqReady", 32'(bus.ReqReady), 32'd1);
    check("rst.LoadData", bus.LoadData, 32'h0);
    check("rst.pulses", {29'd0, bus.LoadValid, bus.StoreDone, bus.AddrError}, 32'd0);
    check("rst.enables", {30'd0, bus.MemoryRead, bus.MemoryWrite}, 32'd0);
    check("rst.MemAddress", 32'(bus.MemAddress), 32'd0);
    check("rst.MemWriteData", bus.MemWriteData, 32'h0);
    step();
    step();
    Reset_n = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 8'h08, 32'hDEADBEEF, 1'b0, "st_word");
    do_req(1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 1'b0, "ld_word");
    check("ld_word.const", bus.LoadData, 32'hDEADBEEF);

    mem[2] = 32'h80FF7F01;
    ref_mem[2] = mem[2];
    do_req(1'b0, 2'b00, 1'b0, 8'h0B, 32'h0, 1'b0, "ldb_s0B");
    check("ldb_s0B.const", bus.LoadData, 32'hFFFFFF80);
    do_req(1'b0, 2'b00, 1'b1, 8'h0B, 32'h0, 1'b0, "ldb_u0B");
    check("ldb_u0B.const", bus.LoadData, 32'h00000080);
    do_req(1'b0, 2'b00, 1'b0, 8'h08, 32'h0, 1'b0, "ldb_s08");
    check("ldb_s08.const", bus.LoadData, 32'h00000001);

    mem[2] = 32'h11223344;
    ref_mem[2] = mem[2];
    do_req(1'b1, 2'b00, 1'b0, 8'h09, 32'h000000AA, 1'b0, "stb_09");
    do_req(1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 1'b0, "rb_stb");
    check("rb_stb.const", bus.LoadData, 32'h1122AA44);
    do_req(1'b1, 2'b01, 1'b0, 8'h0A, 32'h0000BEEF, 1'b0, "sth_0A");
    do_req(1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 1'b0, "rb_sth");
    check("rb_sth.const", bus.LoadData, 32'hBEEFAA44);

    do_req(1'b1, 2'b01, 1'b0, 8'h05, 32'h0000CAFE, 1'b0, "err_half");
    do_req(1'b0, 2'b10, 1'b0, 8'h06, 32'h0, 1'b0, "err_word");
    do_req(1'b1, 2'b11, 1'b0, 8'h04, 32'h55555555, 1'b0, "err_size");

    // Reset lands early in the WRITE cycle, ahead of the negedge write.
    sd0 = sd_cnt;
    wr0 = wr_cnt;
    bus.ReqValid = 1'b1;
    bus.ReqStore = 1'b1;
    bus.ReqSize = 2'b10;
    bus.ReqAddr = 8'h10;
    bus.ReqWData = 32'h12345678;
    step();
    check("rst_mid.write_before", 32'(bus.MemoryWrite), 32'd1);
    Reset_n = 1'b0;
    bus.ReqValid = 1'b0;
    #1;
    check("rst_mid.write_dropped", 32'(bus.MemoryWrite), 32'd0);
    check("rst_mid.ready", 32'(bus.ReqReady), 32'd1);
    step();
    step();
    Reset_n = 1'b1;
    step();
    step();
    check("rst_mid.no_done", 32'(sd_cnt - sd0), 32'd0);
    check("rst_mid.no_write", 32'(wr_cnt - wr0), 32'd0);
    check("rst_mid.mem4", mem[4], ref_mem[4]);

    do_req(1'b0, 2'b10, 1'b0, 8'h00, 32'h0, 1'b1, "b2b_0");
    p0 = last_pulse;
    do_req(1'b0, 2'b10, 1'b0, 8'h04, 32'h0, 1'b1, "b2b_1");
    p1 = last_pulse;
    check("b2b.gap1", 32'(p1 - p0), 32'd3);
    do_req(1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 1'b1, "b2b_2");
    check("b2b.gap2", 32'(last_pulse - p1), 32'd3);
    bus.ReqValid = 1'b0;

    for (int i = 0; i < 60; i++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)), $urandom, 1'b0, "rnd");
    end

    step();
    for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
